mem_word_bridge: RTL and testbench
==================================

# mem_word_bridge

Bridges the CPU's 8/16/32-bit load/store requests onto the byte-wide, handshaked `memory` block. Each CPU access is split into 1, 2 or 4 sequential byte accesses, holding each request until the memory's `ready`, and assembled little-endian. Sits directly upstream of `memory`, between the CPU core and the memory port.

## Interface
- `ADDR_WIDTH`, 8, byte-address width; 2^ADDR_WIDTH equals memory `size` (256).
- `clk` in 1: the single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `cpu_addr` in ADDR_WIDTH: byte address of the lowest byte.
- `cpu_wdata` in 32: store data; bytes taken from the low end.
- `cpu_width` in 2: 00 byte, 01 half, 10 word, 11 treated as word.
- `cpu_read` in 1: load request.
- `cpu_write` in 1: store request.
- `cpu_rdata` out 32: assembled load data, zero-extended.
- `cpu_busy` out 1: high in every non-IDLE state.
- `cpu_done` out 1: one-cycle completion pulse.
- `cpu_error` out 1: one-cycle misalignment pulse (see Configuration).
- `mem_address` out ADDR_WIDTH: to memory `address`.
- `mem_data_out` out 8: to memory `data_in`.
- `mem_data_in` in 8: from memory `data_out`.
- `mem_read` out 1, `mem_write` out 1: memory strobes.
- `mem_ready` in 1: memory completion; read data valid in the same cycle.

## Operation
- FSM states: IDLE, REQ, GAP, DONE.
- IDLE: samples `cpu_read`/`cpu_write`. If both are high, write wins. Latches address, wdata, width and byte count N (1/2/4), clears byte index i, then goes to REQ. Requests are ignored in every other state.
- REQ: drives `mem_address` = latched addr + i (mod 2^ADDR_WIDTH, wrap allowed) and `mem_data_out` = wdata[8i+7:8i]. Holds `mem_read` or `mem_write` high and all mem outputs stable until `mem_ready` is sampled high.
  - On ready for a read, captures `mem_data_in` into rdata byte i.
  - Then goes to GAP if i < N-1, otherwise DONE.
- GAP: one cycle with both strobes low, so memory sees a fresh request. Increments i, then returns to REQ.
- DONE: `cpu_done` = 1 for this cycle only. `cpu_rdata` is updated here, with unaccessed upper bytes set to 0. Returns to IDLE.
- `cpu_rdata` holds its value between loads; stores do not change it.
- `mem_ready` seen outside REQ is ignored.
- Reset values:
  - All outputs are 0.
  - State is IDLE and i is 0.
  - Reset mid-access aborts: strobes go low after the reset edge and no `cpu_done` is issued. Bytes already written stay in memory.

## Timing
- Request accepted at the edge ending cycle 0; REQ starts in cycle 1.
- If memory asserts ready in the d-th REQ cycle (d ≥ 1), each byte costs d+1 cycles.
- `cpu_done` is high in cycle N·(d+1). Word with d=2 gives cycle 12; byte with d=2 gives cycle 3.
- `cpu_busy` is high from cycle 1 through the DONE cycle inclusive.
- A new request may be presented in the cycle after DONE. Back-to-back throughput is one access per N·(d+1)+1 cycles.

## Configuration
- `MEM_BRIDGE_ALIGN_CHECK_EN` defined:
  - In IDLE, a half request with addr[0]=1, or a word request with addr[1:0]≠0, is rejected.
  - The FSM goes straight to DONE with `cpu_error` = 1 and `cpu_done` = 0 in that cycle.
  - No memory strobe is issued and `cpu_rdata` is unchanged.
- Not defined: `cpu_error` is tied to 0. Misaligned accesses proceed byte-wise, with address wrap at 2^ADDR_WIDTH.

## Test plan
- Word store 0xA1B2C3D4 to 0x10, then word load from 0x10, memory delay 2: bytes D4,C3,B2,A1 written at 0x10–0x13. Load `cpu_rdata` = 0xA1B2C3D4, `cpu_done` in cycle 12 of each access.
- Byte load from 0x13 after the above: `cpu_rdata` = 0x000000A1, exactly one `mem_read` phase, `cpu_done` in cycle 3.
- `cpu_read` and `cpu_write` high together with half width, addr 0x20, wdata 0x0000BEEF: two writes (EF to 0x20, BE to 0x21) and no reads.
- Word access at 0xFE, macro undefined: addresses 0xFE, 0xFF, 0x00, 0x01 in order. Macro defined: `cpu_error` pulse in cycle 1, with `mem_read` and `mem_write` never high.
- `reset` asserted while in REQ for byte 2 of a word store: strobes low in the next cycle, `cpu_busy`/`cpu_done` = 0, bytes 0–1 present in memory, and a new request is accepted afterwards.
- `mem_ready` held at 0 for 20 cycles during REQ: address, data and strobe stay stable and `cpu_done` stays 0 until ready arrives.

Source files
------------

// File: rtl/mem_word_bridge_if.sv
// CPU load/store bus and byte-wide memory port seen by mem_word_bridge.
// slave = bridge side, master = CPU core plus memory side.
interface mem_word_bridge_if #(
    parameter int ADDR_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [31:0]           cpu_wdata;
    logic [1:0]            cpu_width;
    logic                  cpu_read;
    logic                  cpu_write;
    logic [31:0]           cpu_rdata;
    logic                  cpu_busy;
    logic                  cpu_done;
    logic                  cpu_error;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [7:0]            mem_data_out;
    logic [7:0]            mem_data_in;
    logic                  mem_read;
    logic                  mem_write;
    logic                  mem_ready;

    modport slave (
        input  cpu_addr, cpu_wdata, cpu_width, cpu_read, cpu_write,
        output cpu_rdata, cpu_busy, cpu_done, cpu_error,
        output mem_address, mem_data_out, mem_read, mem_write,
        input  mem_data_in, mem_ready
    );

    modport master (
        output cpu_addr, cpu_wdata, cpu_width, cpu_read, cpu_write,
        input  cpu_rdata, cpu_busy, cpu_done, cpu_error,
        input  mem_address, mem_data_out, mem_read, mem_write,
        output mem_data_in, mem_ready
    );
endinterface

// File: rtl/mem_word_bridge.sv
// Splits 8/16/32-bit CPU loads/stores into little-endian byte accesses on a handshaked memory.
// Optional MEM_BRIDGE_ALIGN_CHECK_EN rejects misaligned half/word requests with cpu_error.
module mem_word_bridge #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    mem_word_bridge_if.slave  bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]            state_reg;
    logic [1:0]            idx_reg;
    logic [1:0]            last_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [31:0]           wdata_reg;
    logic                  write_reg;
    logic                  err_reg;
    logic [31:0]           rbuf_reg;
    logic [31:0]           rbuf_next;
    logic [31:0]           rdata_reg;
    logic [1:0]            width_last;
    logic                  misaligned;
    logic                  in_req;

    assign in_req = (state_reg == REQ);

    // Index of the final byte: 0 for byte, 1 for half, 3 for word (width 11 acts as word).
    always_comb begin
        width_last = 2'd3;
        case (bus.cpu_width)
            2'b00:   width_last = 2'd0;
            2'b01:   width_last = 2'd1;
            default: width_last = 2'd3;
        endcase
    end

`ifdef MEM_BRIDGE_ALIGN_CHECK_EN
    assign misaligned = ((bus.cpu_width == 2'b01) && bus.cpu_addr[0]) ||
                        (bus.cpu_width[1] && (bus.cpu_addr[1:0] != 2'b00));
    assign bus.cpu_error = (state_reg == DONE) && err_reg;
`else
    assign misaligned    = 1'b0;
    assign bus.cpu_error = 1'b0;
`endif

    // Each lane captures memory data only on the handshake of its own byte.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign rbuf_next[8*gi +: 8] =
                (in_req && bus.mem_ready && !write_reg && (idx_reg == 2'(gi)))
                    ? bus.mem_data_in : rbuf_reg[8*gi +: 8];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            idx_reg   <= 2'd0;
            last_reg  <= 2'd0;
            addr_reg  <= '0;
            wdata_reg <= 32'd0;
            write_reg <= 1'b0;
            err_reg   <= 1'b0;
            rbuf_reg  <= 32'd0;
            rdata_reg <= 32'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.cpu_read || bus.cpu_write) begin
                        addr_reg  <= bus.cpu_addr;
                        wdata_reg <= bus.cpu_wdata;
                        write_reg <= bus.cpu_write;
                        last_reg  <= width_last;
                        idx_reg   <= 2'd0;
                        rbuf_reg  <= 32'd0;
                        err_reg   <= misaligned;
                        state_reg <= misaligned ? DONE : REQ;
                    end
                end
                REQ: begin
                    if (bus.mem_ready) begin
                        rbuf_reg <= rbuf_next;
                        if (idx_reg == last_reg) begin
                            // Publish load data so it is already visible in the DONE cycle.
                            if (!write_reg) begin
                                rdata_reg <= rbuf_next;
                            end
                            state_reg <= DONE;
                        end else begin
                            state_reg <= GAP;
                        end
                    end
                end
                GAP: begin
                    idx_reg   <= idx_reg + 2'd1;
                    state_reg <= REQ;
                end
                default: begin
                    err_reg   <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.cpu_rdata    = rdata_reg;
    assign bus.cpu_busy     = (state_reg != IDLE);
    assign bus.cpu_done     = (state_reg == DONE) && !err_reg;
    assign bus.mem_read     = in_req && !write_reg;
    assign bus.mem_write    = in_req && write_reg;
    assign bus.mem_address  = in_req ? (addr_reg + {{(ADDR_WIDTH-2){1'b0}}, idx_reg}) : '0;
    assign bus.mem_data_out = in_req ? wdata_reg[{idx_reg, 3'b000} +: 8] : 8'd0;
endmodule

// File: tb/tb_mem_word_bridge.sv
// Directed bench for mem_word_bridge with a byte memory model of programmable ready delay.
// Build with MEM_BRIDGE_ALIGN_CHECK_EN defined to exercise the misalignment rejection path.
module tb_mem_word_bridge;
    logic clk = 1'b0;
    logic reset;
    logic mem_init;
    always #5 clk = ~clk;

    mem_word_bridge_if #(.ADDR_WIDTH(8)) bus ();
    mem_word_bridge #(.ADDR_WIDTH(8)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        logic        wr;
        logic        rd;
        logic [1:0]  width;
        logic [7:0]  addr;
        logic [31:0] wdata;
        int          delay;
        logic [31:0] exp_rdata;
    } vec_t;

    // Memory model: ready rises in the d-th consecutive strobe cycle.
    logic [7:0] mem [0:255];
    int         mem_delay = 1;
    int         wait_cnt = 0;
    logic [7:0] log_addr [$];
    logic [7:0] log_data [$];
    logic       log_wr   [$];

    assign bus.mem_ready   = (bus.mem_read || bus.mem_write) && (wait_cnt == mem_delay - 1);
    assign bus.mem_data_in = mem[bus.mem_address];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
            wait_cnt <= 0;
        end else if (bus.mem_ready) begin
            if (bus.mem_write) mem[bus.mem_address] <= bus.mem_data_out;
            log_addr.push_back(bus.mem_address);
            log_data.push_back(bus.mem_write ? bus.mem_data_out : mem[bus.mem_address]);
            log_wr.push_back(bus.mem_write);
            wait_cnt <= 0;
        end else if (bus.mem_read || bus.mem_write) begin
            wait_cnt <= wait_cnt + 1;
        end else begin
            wait_cnt <= 0;
        end
    end

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic start_req(input logic wr, input logic rd, input logic [1:0] width,
                             input logic [7:0] addr, input logic [31:0] wdata);
        @(posedge clk);
        #1;
        bus.cpu_write = wr;
        bus.cpu_read  = rd;
        bus.cpu_width = width;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wdata;
        @(posedge clk);
        #1;
        bus.cpu_write = 1'b0;
        bus.cpu_read  = 1'b0;
    endtask

    // Counts cycles from 1 until done or error; tracks busy and REQ output stability.
    task automatic wait_done(output int dc, output logic er, output logic dn,
                             output logic [31:0] rd, output int busy_bad,
                             output int stab_bad, output int strobe_cycles);
        logic       pend;
        logic [7:0] p_addr, p_data;
        logic       p_rd, p_wr;
        dc = -1; er = 1'b0; dn = 1'b0; rd = 32'd0;
        busy_bad = 0; stab_bad = 0; strobe_cycles = 0;
        pend = 1'b0; p_addr = 8'd0; p_data = 8'd0; p_rd = 1'b0; p_wr = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (!bus.cpu_busy) busy_bad++;
            if (bus.mem_read || bus.mem_write) strobe_cycles++;
            if (pend && (bus.mem_address !== p_addr || bus.mem_data_out !== p_data ||
                         bus.mem_read !== p_rd || bus.mem_write !== p_wr)) stab_bad++;
            pend   = (bus.mem_read || bus.mem_write) && !bus.mem_ready;
            p_addr = bus.mem_address;
            p_data = bus.mem_data_out;
            p_rd   = bus.mem_read;
            p_wr   = bus.mem_write;
            if (bus.cpu_done || bus.cpu_error) begin
                dc = k; er = bus.cpu_error; dn = bus.cpu_done; rd = bus.cpu_rdata;
                break;
            end
            @(posedge clk);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int n, base, dc, bb, sb, sc;
        logic er, dn;
        logic [31:0] rd;
        logic [7:0] a, b;
        n = (v.width == 2'b00) ? 1 : (v.width == 2'b01) ? 2 : 4;
        mem_delay = v.delay;
        base = log_addr.size();
        start_req(v.wr, v.rd, v.width, v.addr, v.wdata);
        wait_done(dc, er, dn, rd, bb, sb, sc);
        check({tag, " done_cycle"}, dc, n * (v.delay + 1));
        check({tag, " rdata"}, rd, v.exp_rdata);
        check({tag, " error"}, {31'd0, er}, 32'd0);
        check({tag, " busy_gaps"}, bb, 32'd0);
        check({tag, " req_stability"}, sb, 32'd0);
        check({tag, " byte_count"}, log_addr.size() - base, n);
        for (int i = 0; i < n; i++) begin
            a = v.addr + 8'(i);
            b = v.wr ? v.wdata[8*i +: 8] : v.exp_rdata[8*i +: 8];
            if (base + i < log_addr.size())
                check($sformatf("%s byte%0d {wr,addr,data}", tag, i),
                      {15'd0, log_wr[base+i], log_addr[base+i], log_data[base+i]},
                      {15'd0, v.wr, a, b});
        end
        $display("access %s: wr=%0d rd=%0d width=%0d addr=0x%02h done_cycle=%0d rdata=0x%08h",
                 tag, v.wr, v.rd, v.width, v.addr, dc, rd);
    endtask

    vec_t vecs [$];

    initial begin
        int dc, bb, sb, sc, base;
        logic er, dn;
        logic [31:0] rd;
        vec_t v;

        // wr, rd, width, addr, wdata, delay, expected rdata
        vecs.push_back('{1'b1, 1'b0, 2'b10, 8'h10, 32'hA1B2C3D4, 2, 32'h00000000});
        vecs.push_back('{1'b0, 1'b1, 2'b10, 8'h10, 32'h00000000, 2, 32'hA1B2C3D4});
        vecs.push_back('{1'b0, 1'b1, 2'b00, 8'h13, 32'h00000000, 2, 32'h000000A1});
        vecs.push_back('{1'b1, 1'b1, 2'b01, 8'h20, 32'h0000BEEF, 1, 32'h000000A1});
        vecs.push_back('{1'b0, 1'b1, 2'b01, 8'h20, 32'h00000000, 1, 32'h0000BEEF});
        vecs.push_back('{1'b0, 1'b1, 2'b11, 8'h10, 32'h00000000, 3, 32'hA1B2C3D4});
        vecs.push_back('{1'b1, 1'b0, 2'b00, 8'h30, 32'h12345678, 1, 32'hA1B2C3D4});
        vecs.push_back('{1'b0, 1'b1, 2'b00, 8'h30, 32'h00000000, 1, 32'h00000078});
        vecs.push_back('{1'b0, 1'b1, 2'b01, 8'h12, 32'h00000000, 1, 32'h0000A1B2});
        vecs.push_back('{1'b1, 1'b0, 2'b01, 8'h12, 32'hFFFF0000, 4, 32'h0000A1B2});
        vecs.push_back('{1'b0, 1'b1, 2'b10, 8'h10, 32'h00000000, 1, 32'h0000C3D4});
        vecs.push_back('{1'b1, 1'b0, 2'b00, 8'h50, 32'h00000099, 21, 32'h0000C3D4});
`ifndef MEM_BRIDGE_ALIGN_CHECK_EN
        vecs.push_back('{1'b1, 1'b0, 2'b10, 8'hFE, 32'h44332211, 1, 32'h0000C3D4});
        vecs.push_back('{1'b0, 1'b1, 2'b10, 8'hFE, 32'h00000000, 2, 32'h44332211});
`endif

        reset = 1'b1;
        mem_init = 1'b1;
        bus.cpu_read = 1'b0; bus.cpu_write = 1'b0; bus.cpu_width = 2'b00;
        bus.cpu_addr = 8'h00; bus.cpu_wdata = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset cpu_rdata", bus.cpu_rdata, 32'd0);
        check("reset busy/done/error", {29'd0, bus.cpu_busy, bus.cpu_done, bus.cpu_error}, 32'd0);
        check("reset strobes", {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
        check("reset mem_address/data", {16'd0, bus.mem_address, bus.mem_data_out}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        mem_init = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

`ifndef MEM_BRIDGE_ALIGN_CHECK_EN
        check("wrap mem[0x00]", {24'd0, mem[8'h00]}, 32'h00000033);
        check("wrap mem[0xFF]", {24'd0, mem[8'hFF]}, 32'h00000022);
`else
        // Misaligned word at 0xFE must be rejected without touching memory.
        base = log_addr.size();
        mem_delay = 1;
        start_req(1'b0, 1'b1, 2'b10, 8'hFE, 32'd0);
        wait_done(dc, er, dn, rd, bb, sb, sc);
        check("align done_cycle", dc, 32'd1);
        check("align cpu_error", {31'd0, er}, 32'd1);
        check("align cpu_done", {31'd0, dn}, 32'd0);
        check("align rdata", rd, 32'h0000C3D4);
        check("align strobe_cycles", sc, 32'd0);
        check("align byte_count", log_addr.size() - base, 32'd0);
        $display("access align: word load 0xFE done_cycle=%0d error=%0d", dc, er);
`endif

        // Reset during REQ for byte 2 of a word store.
        mem_delay = 2;
        start_req(1'b1, 1'b0, 2'b10, 8'h40, 32'h11223344);
        repeat (6) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("abort pre-reset REQ byte2", {23'd0, bus.mem_write, bus.mem_address}, {23'd0, 1'b1, 8'h42});
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort strobes", {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
        check("abort busy/done", {30'd0, bus.cpu_busy, bus.cpu_done}, 32'd0);
        check("abort mem[0x40..0x42]", {8'd0, mem[8'h40], mem[8'h41], mem[8'h42]}, 32'h00443300);
        $display("access abort: word store 0x40 reset in byte2 REQ");
        v = '{1'b0, 1'b1, 2'b01, 8'h40, 32'h00000000, 1, 32'h00003344};
        run_vec(v, "post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
